// File: rtl/clkdiv_seq_ctrl.sv
// Run-time controller for a divide-by-N clock generator. Divisor updates arrive over a
// valid/ready handshake and take effect only at a period boundary, so there are no runt pulses.
module clkdiv_seq_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEF_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_div,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] active_div
);

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_div_q, clk_div_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic             period_end;
  logic             xfer;
  logic             load;
  logic             run_d;
  logic [WIDTH:0]   half_d;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    active_d   = active_q;
    pend_div_d = pend_div_q;
    pend_vld_d = pend_vld_q;
    load       = 1'b0;
    period_end = (count_q == active_q - WIDTH'(1));
    xfer       = cfg_valid & ~pend_vld_q;

    unique case (state_q)
      StIdle: begin
        count_d = '0;
        if (en) begin
          state_d = StRun;
          load    = pend_vld_q;
        end
      end
      StRun, StStop: begin
        // STOP behaves like RUN except that it ends the run at the next boundary
        if (period_end) begin
          count_d = '0;
          load    = pend_vld_q;
          state_d = en ? StRun : StIdle;
        end else begin
          count_d = count_q + WIDTH'(1);
          state_d = en ? StRun : StStop;
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase

    if (load) begin
      active_d   = pend_div_q;
      pend_vld_d = 1'b0;
    end
    if (xfer && (cfg_div >= WIDTH'(2))) begin
      pend_div_d = cfg_div;
      pend_vld_d = 1'b1;
    end
    err_d = xfer && (cfg_div < WIDTH'(2));

    // One extra bit so that the maximum divisor does not wrap in (N+1)>>1
    run_d     = (state_d != StIdle);
    half_d    = ({1'b0, active_d} + (WIDTH+1)'(1)) >> 1;
    clk_div_d = run_d && ({1'b0, count_d} < half_d);
    tick_d    = run_d && (count_d == active_d - WIDTH'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      active_q   <= WIDTH'(DEF_DIV);
      pend_div_q <= '0;
      pend_vld_q <= 1'b0;
      clk_div_q  <= 1'b0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      active_q   <= active_d;
      pend_div_q <= pend_div_d;
      pend_vld_q <= pend_vld_d;
      clk_div_q  <= clk_div_d;
      tick_q     <= tick_d;
      err_q      <= err_d;
    end
  end

  assign cfg_ready  = ~pend_vld_q;
  assign cfg_err    = err_q;
  assign clk_div    = clk_div_q;
  assign tick       = tick_q;
  assign busy       = (state_q != StIdle);
  assign active_div = active_q;

endmodule

// File: tb/tb_clkdiv_seq_ctrl.sv
// Bench for clkdiv_seq_ctrl: directed vector table, hand-written corner sequences and
// random stimulus, all compared against a period/phase reference model.
module tb_clkdiv_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_err;
  logic       clk_div;
  logic       tick;
  logic       busy;
  logic [7:0] active_div;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a run flag, the phase within the period, the divisor and a pending queue
  int m_n;
  int m_phase;
  bit m_run;
  bit m_err;
  int m_pend[$];

  clkdiv_seq_ctrl #(.WIDTH(8), .DEF_DIV(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clk_div   (clk_div),
    .tick      (tick),
    .busy      (busy),
    .active_div(active_div)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       vld;
    logic [7:0] div;
    logic       e_clk;
    logic       e_tick;
    logic       e_busy;
    logic       e_rdy;
    logic       e_err;
    logic [7:0] e_act;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_n     = 3;
    m_phase = 0;
    m_run   = 1'b0;
    m_err   = 1'b0;
    m_pend.delete();
  endtask

  // One clock edge of the specified behaviour, using the inputs present at that edge
  task automatic model_step();
    bit xfer;
    xfer = cfg_valid && (m_pend.size() == 0);
    if (!m_run) begin
      if (en) begin
        m_run   = 1'b1;
        m_phase = 0;
        if (m_pend.size() != 0) m_n = m_pend.pop_front();
      end
    end else if (m_phase == m_n - 1) begin
      if (m_pend.size() != 0) m_n = m_pend.pop_front();
      m_phase = 0;
      m_run   = en;
    end else begin
      m_phase++;
    end
    m_err = xfer && (cfg_div < 2);
    if (xfer && cfg_div >= 2) m_pend.push_back(int'(cfg_div));
  endtask

  task automatic check_all(input string tag);
    check({tag, "_clk_div"}, clk_div, (m_run && m_phase < (m_n + 1) / 2) ? 1 : 0);
    check({tag, "_tick"}, tick, (m_run && m_phase == m_n - 1) ? 1 : 0);
    check({tag, "_busy"}, busy, m_run ? 1 : 0);
    check({tag, "_cfg_ready"}, cfg_ready, (m_pend.size() == 0) ? 1 : 0);
    check({tag, "_cfg_err"}, cfg_err, m_err ? 1 : 0);
    check({tag, "_active_div"}, active_div, m_n);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    rst = 1'b0;
  endtask

  initial begin
    int highs;
    int ticks;
    int budget;
    rst       = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    model_reset();

    //            en  vld div  clk tick busy rdy err act
    tbl[0]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3};
    tbl[1]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3};
    tbl[2]  = '{1'b1, 1'b1, 8'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3};
    tbl[3]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4};
    tbl[4]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4};
    tbl[5]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4};
    tbl[6]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd4};
    tbl[7]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4};
    tbl[8]  = '{1'b1, 1'b1, 8'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd4};
    tbl[9]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4};
    tbl[10] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd4};
    tbl[11] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4};

    do_reset();
    check("reset_active_div", active_div, 3);
    check("reset_cfg_ready", cfg_ready, 1);

    for (int i = 0; i < 12; i++) begin
      en        = tbl[i].en;
      cfg_valid = tbl[i].vld;
      cfg_div   = tbl[i].div;
      cycle("tbl");
      check($sformatf("tbl%0d_clk_div", i), clk_div, tbl[i].e_clk);
      check($sformatf("tbl%0d_tick", i), tick, tbl[i].e_tick);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      check($sformatf("tbl%0d_cfg_ready", i), cfg_ready, tbl[i].e_rdy);
      check($sformatf("tbl%0d_cfg_err", i), cfg_err, tbl[i].e_err);
      check($sformatf("tbl%0d_active_div", i), active_div, tbl[i].e_act);
    end
    cfg_valid = 1'b0;

    // Stop at count 0 of an N=5 period: the period finishes, then idle
    cfg_valid = 1'b1;
    cfg_div   = 8'd5;
    cycle("t4_cfg");
    cfg_valid = 1'b0;
    budget = 0;
    while (!(m_n == 5 && m_phase == 0) && budget < 20) begin
      cycle("t4_wait");
      budget++;
    end
    check("t4_reach_n5", (budget < 20) ? 1 : 0, 1);
    en = 1'b0;
    highs = clk_div;
    for (int i = 0; i < 4; i++) begin
      cycle("t4_stop");
      highs += clk_div;
      check("t4_busy_stopping", busy, 1);
    end
    check("t4_highs", highs, 3);
    check("t4_last_tick", tick, 1);
    cycle("t4_idle");
    check("t4_idle_busy", busy, 0);
    check("t4_idle_clk_div", clk_div, 0);
    en = 1'b1;
    cycle("t4_restart");
    check("t4_restart_clk_div", clk_div, 1);
    check("t4_restart_active", active_div, 5);

    // Async reset mid-run with an update pending
    cycle("t5_run");
    cfg_valid = 1'b1;
    cfg_div   = 8'd7;
    cycle("t5_cfg");
    cfg_valid = 1'b0;
    check("t5_pending", cfg_ready, 0);
    #3;
    rst = 1'b1;
    #1;
    check("t5_async_clk_div", clk_div, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_ready", cfg_ready, 1);
    check("t5_async_active", active_div, 3);
    check("t5_async_tick", tick, 0);
    model_reset();
    @(posedge clk);
    #1;
    check_all("t5_held");
    rst = 1'b0;

    // Maximum divisor: 255-cycle period, high for 128; a second offer stalls until the load
    en = 1'b1;
    cycle("t6_start");
    cfg_valid = 1'b1;
    cfg_div   = 8'd255;
    cycle("t6_cfg");
    cfg_div = 8'd10;
    budget  = 0;
    while (m_n != 255 && budget < 10) begin
      check("t6_stall", cfg_ready, 0);
      cycle("t6_wait");
      budget++;
    end
    check("t6_loaded", active_div, 255);
    highs = clk_div;
    ticks = tick;
    for (int i = 1; i < 255; i++) begin
      cycle("t6_period");
      highs += clk_div;
      ticks += tick;
    end
    check("t6_highs", highs, 128);
    check("t6_ticks", ticks, 1);
    check("t6_end_tick", tick, 1);
    cycle("t6_wrap");
    check("t6_wrap_active", active_div, 10);
    check("t6_wrap_clk_div", clk_div, 1);
    cfg_valid = 1'b0;

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) cfg_div = 8'($urandom_range(0, 255));
      else cfg_div = 8'($urandom_range(0, 7));
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
